// File: rtl/alu_operand_collector_if.sv
// Request-side handshake bundle for the alu operand collector.
// The master presents operation beats; the slave (collector) returns in_ready.
interface alu_operand_collector_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CMD_WIDTH  = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic                  in_mode;
  logic [CMD_WIDTH-1:0]  in_cmd;
  logic                  in_cin;
  logic [1:0]            in_inp_valid;
  logic [DATA_WIDTH-1:0] in_opa;
  logic [DATA_WIDTH-1:0] in_opb;

  modport master (
    output in_valid, in_mode, in_cmd, in_cin, in_inp_valid, in_opa, in_opb,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_mode, in_cmd, in_cin, in_inp_valid, in_opa, in_opb,
    output in_ready
  );
endinterface

// File: rtl/alu_operand_collector.sv
// alu_operand_collector: gathers opa/opb (possibly from separate beats),
// waits a bounded time for a missing operand, then issues one registered
// request to the alu and holds off new requests for the alu multiply latency.
module alu_operand_collector #(
  parameter int DATA_WIDTH = 8,
  parameter int CMD_WIDTH  = 4,
  parameter int TIMEOUT    = 16,
  parameter int ISSUE_GAP  = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  alu_operand_collector_if.slave req,
  output logic                   CE,
  output logic                   mode,
  output logic [CMD_WIDTH-1:0]   CMD,
  output logic                   CIN,
  output logic [DATA_WIDTH-1:0]  opa,
  output logic [DATA_WIDTH-1:0]  opb,
  output logic [1:0]             INP_VALID,
  output logic                   issue,
  output logic                   timeout_err
);

  localparam int TMO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int GAP_W = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP + 1) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(ISSUE_GAP - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ISSUE, S_GAP} state_t;

  state_t state_reg, state_next;
  logic [TMO_W-1:0] tmo_cnt_reg;
  logic [GAP_W-1:0] gap_cnt_reg;
  logic tmo_fire;

  // Operand holding set (what has been collected for the pending request)
  logic                  hold_mode_reg, hold_mode_next;
  logic [CMD_WIDTH-1:0]  hold_cmd_reg, hold_cmd_next;
  logic                  hold_cin_reg, hold_cin_next;
  logic [1:0]            hold_vld_reg, hold_vld_next;
  logic [DATA_WIDTH-1:0] hold_opa_reg, hold_opa_next;
  logic [DATA_WIDTH-1:0] hold_opb_reg, hold_opb_next;
  logic [1:0]            need_next;
  logic                  complete;

  // Registered outputs
  logic                  ce_reg;
  logic                  in_ready_reg, ready_next;
  logic                  issue_reg, issue_next;
  logic                  err_reg, err_next;
  logic                  mode_reg;
  logic [CMD_WIDTH-1:0]  cmd_reg;
  logic                  cin_reg;
  logic [1:0]            vld_reg;
  logic [DATA_WIDTH-1:0] opa_reg, opb_reg;

  logic accept;

  // Which operands a command consumes: bit0 = opa, bit1 = opb, 00 = none.
  function automatic logic [1:0] need_mask(input logic m, input logic [CMD_WIDTH-1:0] c);
    int ci;
    logic [1:0] r;
    ci = int'(c);
    r  = 2'b00;
    if (m) begin
      case (ci)
        0, 1, 2, 3, 8, 9, 10: r = 2'b11;
        4, 5:                 r = 2'b01;
        6, 7:                 r = 2'b10;
        default:              r = 2'b00;
      endcase
    end else begin
      case (ci)
        0, 1, 2, 3, 4, 5, 12, 13: r = 2'b11;
        6, 8, 10:                 r = 2'b01;
        7, 9, 11:                 r = 2'b10;
        default:                  r = 2'b00;
      endcase
    end
    return r;
  endfunction

  assign accept = req.in_valid && in_ready_reg;

  // Merge an accepted beat into the held set; IDLE starts a fresh set.
  always_comb begin
    hold_mode_next = hold_mode_reg;
    hold_cmd_next  = hold_cmd_reg;
    hold_cin_next  = hold_cin_reg;
    hold_vld_next  = hold_vld_reg;
    hold_opa_next  = hold_opa_reg;
    hold_opb_next  = hold_opb_reg;
    if (accept) begin
      if (state_reg == S_IDLE) begin
        hold_mode_next = req.in_mode;
        hold_cmd_next  = req.in_cmd;
        hold_cin_next  = req.in_cin;
        hold_vld_next  = req.in_inp_valid;
        hold_opa_next  = req.in_inp_valid[0] ? req.in_opa : '0;
        hold_opb_next  = req.in_inp_valid[1] ? req.in_opb : '0;
      end else begin
        hold_vld_next = hold_vld_reg | req.in_inp_valid;
        if (req.in_inp_valid[0]) hold_opa_next = req.in_opa;
        if (req.in_inp_valid[1]) hold_opb_next = req.in_opb;
      end
    end
    need_next = need_mask(hold_mode_next, hold_cmd_next);
    complete  = (need_next & ~hold_vld_next) == 2'b00;
  end

  // Held operand registers; reset drops any partially collected request.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_mode_reg <= 1'b0;
      hold_cmd_reg  <= '0;
      hold_cin_reg  <= 1'b0;
      hold_vld_reg  <= 2'b00;
      hold_opa_reg  <= '0;
      hold_opb_reg  <= '0;
    end else begin
      hold_mode_reg <= hold_mode_next;
      hold_cmd_reg  <= hold_cmd_next;
      hold_cin_reg  <= hold_cin_next;
      hold_vld_reg  <= hold_vld_next;
      hold_opa_reg  <= hold_opa_next;
      hold_opb_reg  <= hold_opb_next;
    end
  end

  // State register plus wait/gap counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      tmo_cnt_reg <= '0;
      gap_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      tmo_cnt_reg <= (state_reg == S_WAIT && state_next == S_WAIT) ? tmo_cnt_reg + 1'b1 : '0;
      gap_cnt_reg <= (state_reg == S_GAP && state_next == S_GAP) ? gap_cnt_reg + 1'b1 : '0;
    end
  end

  // Next-state logic; completion on the last wait cycle beats the timeout.
  always_comb begin
    state_next = state_reg;
    tmo_fire   = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (accept) state_next = complete ? S_ISSUE : S_WAIT;
      end
      S_WAIT: begin
        if (complete) begin
          state_next = S_ISSUE;
        end else if (tmo_cnt_reg == TMO_LAST) begin
          state_next = S_ISSUE;
          tmo_fire   = 1'b1;
        end
      end
      S_ISSUE: state_next = S_GAP;
      S_GAP: begin
        if (gap_cnt_reg == GAP_LAST) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Output decode from the upcoming state so outputs register with it.
  always_comb begin
    ready_next = (state_next == S_IDLE) || (state_next == S_WAIT);
    issue_next = (state_next == S_ISSUE);
    err_next   = tmo_fire;
  end

  // Output registers; alu-side values change only when a request issues.
  always_ff @(posedge clk) begin
    if (rst) begin
      ce_reg       <= 1'b1;
      in_ready_reg <= 1'b0;
      issue_reg    <= 1'b0;
      err_reg      <= 1'b0;
      mode_reg     <= 1'b0;
      cmd_reg      <= '0;
      cin_reg      <= 1'b0;
      vld_reg      <= 2'b00;
      opa_reg      <= '0;
      opb_reg      <= '0;
    end else begin
      ce_reg       <= 1'b1;
      in_ready_reg <= ready_next;
      issue_reg    <= issue_next;
      err_reg      <= err_next;
      if (issue_next) begin
        mode_reg <= hold_mode_next;
        cmd_reg  <= hold_cmd_next;
        cin_reg  <= hold_cin_next;
        vld_reg  <= hold_vld_next;
        opa_reg  <= hold_opa_next;
        opb_reg  <= hold_opb_next;
      end
    end
  end

  assign req.in_ready = in_ready_reg;
  assign CE           = ce_reg;
  assign mode         = mode_reg;
  assign CMD          = cmd_reg;
  assign CIN          = cin_reg;
  assign opa          = opa_reg;
  assign opb          = opb_reg;
  assign INP_VALID    = vld_reg;
  assign issue        = issue_reg;
  assign timeout_err  = err_reg;

endmodule

// File: tb/tb_alu_operand_collector.sv
// Testbench for alu_operand_collector: directed scenarios plus randomized
// requests checked against a cycle-count/operand-set reference model.
module tb_alu_operand_collector;

  localparam int TIMEOUT   = 16;
  localparam int ISSUE_GAP = 3;

  typedef struct packed {
    int         cyc;
    logic       mode;
    logic [3:0] cmd;
    logic       cin;
    logic [1:0] vld;
    logic [7:0] opa;
    logic [7:0] opb;
    logic       err;
  } issue_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic       ce, alu_mode, alu_cin, issue, timeout_err;
  logic [3:0] alu_cmd;
  logic [7:0] alu_opa, alu_opb;
  logic [1:0] alu_vld;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  issue_t issue_q[$];
  issue_t mon_rec;

  alu_operand_collector_if #(.DATA_WIDTH(8), .CMD_WIDTH(4)) bus ();

  alu_operand_collector #(
    .DATA_WIDTH(8), .CMD_WIDTH(4), .TIMEOUT(TIMEOUT), .ISSUE_GAP(ISSUE_GAP)
  ) dut (
    .clk(clk), .rst(rst), .req(bus),
    .CE(ce), .mode(alu_mode), .CMD(alu_cmd), .CIN(alu_cin),
    .opa(alu_opa), .opb(alu_opb), .INP_VALID(alu_vld),
    .issue(issue), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every issued request with the cycle it appeared in.
  always @(negedge clk) begin
    if (!rst && issue === 1'b1) begin
      mon_rec = '{cyc: cyc, mode: alu_mode, cmd: alu_cmd, cin: alu_cin, vld: alu_vld,
                  opa: alu_opa, opb: alu_opb, err: timeout_err};
      issue_q.push_back(mon_rec);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got hang required finish");
    $fatal(1, "watchdog");
  end

  // Operands a command needs: bit0 opa, bit1 opb.
  function automatic logic [1:0] ref_need(input logic m, input int c);
    if (m) begin
      if (c inside {[0:3], [8:10]}) return 2'b11;
      if (c inside {4, 5}) return 2'b01;
      if (c inside {6, 7}) return 2'b10;
    end else begin
      if (c inside {[0:5], 12, 13}) return 2'b11;
      if (c inside {6, 8, 10}) return 2'b01;
      if (c inside {7, 9, 11}) return 2'b10;
    end
    return 2'b00;
  endfunction

  task automatic send_beat(input logic m, input logic [3:0] c, input logic ci,
                           input logic [1:0] iv, input logic [7:0] a, input logic [7:0] b,
                           output int acc);
    bit done;
    done = 0;
    acc  = -1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      bus.in_valid     = 1'b1;
      bus.in_mode      = m;
      bus.in_cmd       = c;
      bus.in_cin       = ci;
      bus.in_inp_valid = iv;
      bus.in_opa       = a;
      bus.in_opb       = b;
      if (bus.in_ready === 1'b1) begin
        @(posedge clk);
        #1;
        acc  = cyc;
        done = 1;
      end
    end
    bus.in_valid = 1'b0;
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL send_beat: in_ready got 0 for 200 cycles, required 1");
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic get_issue(output issue_t r, output bit ok);
    ok = 0;
    r  = '0;
    for (int i = 0; i < 4 * TIMEOUT + 20; i++) begin
      if (issue_q.size() != 0) break;
      @(posedge clk);
    end
    if (issue_q.size() != 0) begin
      r  = issue_q.pop_front();
      ok = 1;
    end
  endtask

  task automatic test_reset();
    logic [26:0] outs;
    bus.in_valid = 1'b0; bus.in_mode = 1'b0; bus.in_cmd = 4'h0; bus.in_cin = 1'b0;
    bus.in_inp_valid = 2'b00; bus.in_opa = 8'h00; bus.in_opb = 8'h00;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (bus.in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ready: got %b required 0", bus.in_ready);
    end
    outs = {ce, alu_mode, alu_cmd, alu_cin, alu_opa, alu_opb, alu_vld, issue, timeout_err};
    vectors++;
    if (outs !== {1'b1, 26'd0}) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h required %h", outs, {1'b1, 26'd0});
    end
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_after_reset: got %b required 1", bus.in_ready);
    end
    $display("reset: in_ready=%b CE=%b", bus.in_ready, ce);
  endtask

  task automatic test_full_beat();
    int a, lows;
    issue_t got, exp;
    bit ok;
    send_beat(1'b1, 4'd0, 1'b1, 2'b11, 8'h12, 8'h34, a);
    lows = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.in_ready === 1'b0) lows++;
      else break;
    end
    vectors++;
    if (lows != 1 + ISSUE_GAP) begin
      miscompares++;
      $display("FAIL full_beat_gap: in_ready low %0d cycles, required %0d", lows, 1 + ISSUE_GAP);
    end
    exp = '{cyc: a, mode: 1'b1, cmd: 4'd0, cin: 1'b1, vld: 2'b11, opa: 8'h12, opb: 8'h34, err: 1'b0};
    get_issue(got, ok);
    vectors++;
    if (!ok || got !== exp) begin
      miscompares++;
      $display("FAIL full_beat: got %p (seen=%0d) required %p", got, ok, exp);
    end
    $display("full_beat: issue at cycle %0d, ready low %0d cycles", got.cyc, lows);
  endtask

  task automatic test_split();
    int a, a2;
    issue_t got, exp;
    bit ok;
    send_beat(1'b1, 4'd0, 1'b0, 2'b01, 8'hFF, 8'hEE, a);
    idle(4);
    send_beat(1'b0, 4'd7, 1'b1, 2'b10, 8'h33, 8'h01, a2);
    vectors++;
    if (a2 !== a + 5) begin
      miscompares++;
      $display("FAIL split_accept: second beat accepted at %0d, required %0d", a2, a + 5);
    end
    exp = '{cyc: a + 5, mode: 1'b1, cmd: 4'd0, cin: 1'b0, vld: 2'b11, opa: 8'hFF, opb: 8'h01, err: 1'b0};
    get_issue(got, ok);
    vectors++;
    if (!ok || got !== exp) begin
      miscompares++;
      $display("FAIL split: got %p (seen=%0d) required %p", got, ok, exp);
    end
    $display("split: issue at cycle %0d vld=%b", got.cyc, got.vld);
  endtask

  task automatic test_timeout();
    int a;
    issue_t got, exp;
    bit ok;
    send_beat(1'b0, 4'd1, 1'b1, 2'b01, 8'h5A, 8'hC3, a);
    exp = '{cyc: a + TIMEOUT, mode: 1'b0, cmd: 4'd1, cin: 1'b1, vld: 2'b01, opa: 8'h5A, opb: 8'h00, err: 1'b1};
    get_issue(got, ok);
    vectors++;
    if (!ok || got !== exp) begin
      miscompares++;
      $display("FAIL timeout: got %p (seen=%0d) required %p", got, ok, exp);
    end
    $display("timeout: issue at cycle %0d err=%b", got.cyc, got.err);
  endtask

  task automatic test_single_operand();
    int a;
    issue_t got, exp;
    bit ok;
    send_beat(1'b1, 4'd4, 1'b0, 2'b01, 8'h7F, 8'h99, a);
    exp = '{cyc: a, mode: 1'b1, cmd: 4'd4, cin: 1'b0, vld: 2'b01, opa: 8'h7F, opb: 8'h00, err: 1'b0};
    get_issue(got, ok);
    vectors++;
    if (!ok || got !== exp) begin
      miscompares++;
      $display("FAIL single_opa: got %p (seen=%0d) required %p", got, ok, exp);
    end
    send_beat(1'b0, 4'd15, 1'b1, 2'b11, 8'hA5, 8'h3C, a);
    exp = '{cyc: a, mode: 1'b0, cmd: 4'd15, cin: 1'b1, vld: 2'b11, opa: 8'hA5, opb: 8'h3C, err: 1'b0};
    get_issue(got, ok);
    vectors++;
    if (!ok || got !== exp) begin
      miscompares++;
      $display("FAIL no_operand_cmd: got %p (seen=%0d) required %p", got, ok, exp);
    end
    $display("single_operand: last issue at cycle %0d", got.cyc);
  endtask

  task automatic test_reset_mid_wait();
    int a;
    logic [26:0] outs;
    issue_t got, exp;
    bit ok;
    send_beat(1'b1, 4'd0, 1'b0, 2'b01, 8'hAA, 8'h00, a);
    idle(3);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (bus.in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL midwait_reset_ready: got %b required 0", bus.in_ready);
    end
    outs = {ce, alu_mode, alu_cmd, alu_cin, alu_opa, alu_opb, alu_vld, issue, timeout_err};
    vectors++;
    if (outs !== {1'b1, 26'd0}) begin
      miscompares++;
      $display("FAIL midwait_reset_outputs: got %h required %h", outs, {1'b1, 26'd0});
    end
    rst = 1'b0;
    vectors++;
    if (issue_q.size() != 0) begin
      miscompares++;
      $display("FAIL midwait_reset_spurious: got %0d issues required 0", issue_q.size());
      issue_q.delete();
    end
    send_beat(1'b1, 4'd0, 1'b0, 2'b10, 8'h11, 8'h55, a);
    exp = '{cyc: a + TIMEOUT, mode: 1'b1, cmd: 4'd0, cin: 1'b0, vld: 2'b10, opa: 8'h00, opb: 8'h55, err: 1'b1};
    get_issue(got, ok);
    vectors++;
    if (!ok || got !== exp) begin
      miscompares++;
      $display("FAIL midwait_reset_discard: got %p (seen=%0d) required %p", got, ok, exp);
    end
    $display("reset_mid_wait: post-reset issue at cycle %0d vld=%b", got.cyc, got.vld);
  endtask

  task automatic test_completion_at_limit();
    int a, a2;
    issue_t got, exp;
    bit ok;
    send_beat(1'b1, 4'd2, 1'b1, 2'b10, 8'h00, 8'h44, a);
    idle(TIMEOUT - 1);
    send_beat(1'b1, 4'd2, 1'b1, 2'b01, 8'h21, 8'h00, a2);
    vectors++;
    if (a2 !== a + TIMEOUT) begin
      miscompares++;
      $display("FAIL limit_accept: completing beat accepted at %0d, required %0d", a2, a + TIMEOUT);
    end
    exp = '{cyc: a + TIMEOUT, mode: 1'b1, cmd: 4'd2, cin: 1'b1, vld: 2'b11, opa: 8'h21, opb: 8'h44, err: 1'b0};
    get_issue(got, ok);
    vectors++;
    if (!ok || got !== exp) begin
      miscompares++;
      $display("FAIL completion_at_limit: got %p (seen=%0d) required %p", got, ok, exp);
    end
    $display("completion_at_limit: issue at cycle %0d err=%b", got.cyc, got.err);
  endtask

  task automatic test_back_to_back();
    int acc[4];
    logic [7:0] av[4];
    logic [7:0] bv[4];
    issue_t got, exp;
    bit ok;
    int prev;
    for (int i = 0; i < 4; i++) begin
      av[i] = 8'($urandom);
      bv[i] = 8'($urandom);
      send_beat(1'b1, 4'd1, 1'b0, 2'b11, av[i], bv[i], acc[i]);
    end
    prev = -1;
    for (int i = 0; i < 4; i++) begin
      get_issue(got, ok);
      exp = '{cyc: acc[i], mode: 1'b1, cmd: 4'd1, cin: 1'b0, vld: 2'b11, opa: av[i], opb: bv[i], err: 1'b0};
      vectors++;
      if (!ok || got !== exp) begin
        miscompares++;
        $display("FAIL back_to_back[%0d]: got %p (seen=%0d) required %p", i, got, ok, exp);
      end
      if (i > 0) begin
        vectors++;
        if (got.cyc - prev != ISSUE_GAP + 2) begin
          miscompares++;
          $display("FAIL back_to_back_spacing[%0d]: got %0d required %0d", i, got.cyc - prev, ISSUE_GAP + 2);
        end
      end
      prev = got.cyc;
      $display("back_to_back[%0d]: issue at cycle %0d", i, got.cyc);
    end
  endtask

  task automatic test_random(input int n);
    for (int t = 0; t < n; t++) begin
      logic m, ci, m2, ci2;
      logic [3:0] c, c2;
      logic [1:0] iv1, iv2, nd, have;
      logic [7:0] a1, b1, a2, b2;
      int a, a2c, d;
      issue_t got, exp;
      bit ok;
      m   = 1'($urandom_range(0, 1));
      c   = 4'($urandom_range(0, 15));
      ci  = 1'($urandom_range(0, 1));
      iv1 = 2'($urandom_range(0, 3));
      a1  = 8'($urandom);
      b1  = 8'($urandom);
      nd  = ref_need(m, int'(c));
      send_beat(m, c, ci, iv1, a1, b1, a);
      have = iv1;
      exp = '{cyc: a, mode: m, cmd: c, cin: ci, vld: 2'b00,
              opa: iv1[0] ? a1 : 8'h00, opb: iv1[1] ? b1 : 8'h00, err: 1'b0};
      if ((nd & ~iv1) != 2'b00) begin
        if ($urandom_range(0, 2) != 0) begin
          d   = $urandom_range(1, TIMEOUT);
          m2  = 1'($urandom_range(0, 1));
          c2  = 4'($urandom_range(0, 15));
          ci2 = 1'($urandom_range(0, 1));
          iv2 = 2'($urandom_range(0, 3));
          a2  = 8'($urandom);
          b2  = 8'($urandom);
          idle(d - 1);
          send_beat(m2, c2, ci2, iv2, a2, b2, a2c);
          vectors++;
          if (a2c !== a + d) begin
            miscompares++;
            $display("FAIL random_accept[%0d]: second beat accepted at %0d, required %0d", t, a2c, a + d);
          end
          have = have | iv2;
          if (iv2[0]) exp.opa = a2;
          if (iv2[1]) exp.opb = b2;
          if ((nd & ~have) == 2'b00) begin
            exp.cyc = a + d;
          end else begin
            exp.cyc = a + TIMEOUT;
            exp.err = 1'b1;
          end
        end else begin
          exp.cyc = a + TIMEOUT;
          exp.err = 1'b1;
        end
      end
      exp.vld = have;
      get_issue(got, ok);
      vectors++;
      if (!ok || got !== exp) begin
        miscompares++;
        $display("FAIL random[%0d]: got %p (seen=%0d) required %p", t, got, ok, exp);
      end
      $display("random[%0d]: mode=%0d cmd=%0d vld=%b issue@%0d err=%b", t, m, c, got.vld, got.cyc, got.err);
    end
  endtask

  initial begin
    test_reset();
    test_full_beat();
    test_split();
    test_timeout();
    test_single_operand();
    test_reset_mid_wait();
    test_completion_at_limit();
    test_back_to_back();
    test_random(60);
    idle(ISSUE_GAP + 4);
    vectors++;
    if (issue_q.size() != 0) begin
      miscompares++;
      $display("FAIL spurious_issues: got %0d unexpected issues required 0", issue_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
